register_burst_reader: RTL and testbench
========================================

# register_burst_reader

Read-side client for the 8-bit `register_file`: it accepts a burst request (base address, count), walks the register file's address port one register per cycle, and streams the contents out on a valid/ready interface with an end-of-burst marker. It sits between the register file and any consumer that unloads tensor-core operand or result registers, such as a host readback path or a debug dump. Writes into the register file stay with the existing writer; an external mux arbitrates the shared address port using `register_enable`.

## Interface
Parameters:
- `NUMBER_OF_REGISTERS`, default 8: depth of the attached register file. Need not be a power of two.
- `ADDRESS_WIDTH`, default `$clog2(NUMBER_OF_REGISTERS)`: width of register addresses.
- `COUNT_WIDTH`, default `$clog2(NUMBER_OF_REGISTERS)+1`: width of the burst length field.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_valid`  in  1  burst request valid.
- `start_ready`  out  1  high only in IDLE.
- `start_address`  in  ADDRESS_WIDTH  first register of the burst.
- `start_count`  in  COUNT_WIDTH  number of beats to stream.
- `register_enable`  out  1  high while the block owns the register file address port.
- `register_address`  out  ADDRESS_WIDTH  address driven to the register file.
- `register_read_data`  in  8  combinational read data returned by the register file.
- `out_valid`  out  1  an output beat is present.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  8  register contents.
- `out_last`  out  1  marks the final beat of the burst.
- `done`  out  1  one-cycle pulse after the last beat is accepted.
- `error`  out  1  one-cycle pulse when a request is rejected.

## Operation
- The FSM has two states: IDLE and STREAM.
- **IDLE**
  - `start_ready` is 1.
  - A request is accepted on a rising edge where `start_valid & start_ready`.
  - On acceptance the block latches the pointer to `start_address` and the remaining count to `start_count`.
- **Rejection**
  - A request is rejected if `start_address >= NUMBER_OF_REGISTERS`.
  - When the macro is absent, a request is also rejected if `start_address + start_count > NUMBER_OF_REGISTERS`.
  - On rejection: pulse `error` for one cycle, stay in IDLE, produce no beats.
- **Zero-length burst:** `start_count == 0` moves straight to a `done` pulse with no beats and stays in IDLE.
- **STREAM**
  - `register_enable` is 1 and `register_address` equals the pointer.
  - There is a single output register. On any edge where remaining > 0 and (`!out_valid | out_ready`):
    - `out_data` captures `register_read_data`;
    - `out_valid` is set to 1;
    - `out_last` is set to (remaining == 1);
    - the pointer advances and remaining decrements.
  - If a beat is accepted and nothing new is loaded, `out_valid` clears.
  - When the beat carrying `out_last` is accepted: return to IDLE and pulse `done` on the following cycle.
- **Pointer advance:** `ptr == NUMBER_OF_REGISTERS-1 ? 0 : ptr+1`. This uses an explicit compare, never bit truncation.
- **Output stability:** while `out_valid & !out_ready`, the values of `out_data` and `out_last` are held stable.
- **Simultaneous write:** if the writer updates the addressed register in the same cycle as a capture, the pre-write value is streamed, because the write lands on the same edge.
- **Reset values:** state IDLE, `out_valid` 0, `out_data` 0, `out_last` 0, `done` 0, `error` 0, pointer 0, remaining 0, `register_enable` 0. Reset asserted mid-burst abandons the burst immediately.

## Timing
- Request accepted at edge E0. STREAM is active from E0. The first beat is captured at E1, so `out_valid` is high after E1.
- Latency from request acceptance to the first beat is 1 cycle.
- With `out_ready` held high, throughput is 1 beat per cycle. N beats occupy edges E1..EN.
- `done` is high for the cycle after the edge on which the last beat handshakes.
- `error` is high for the cycle after the rejecting edge. `start_ready` stays 1 during that cycle.
- `start_ready` returns to 1 in the same cycle `done` is high.

## Configuration
- The macro is `REGISTER_BURST_READER_WRAP_EN`.
- **Defined:** bursts wrap modulo `NUMBER_OF_REGISTERS`, and any `start_count` is legal, including counts larger than `NUMBER_OF_REGISTERS`, which revisit registers. Only an out-of-range `start_address` raises `error`.
- **Undefined:** bursts that run past the last register are rejected with `error`.

## Structure
- Shared package `register_file_pkg` holds:
  - `REGISTER_DATA_WIDTH = 8`;
  - the `burst_state_t` enum {IDLE, STREAM};
  - a `burst_request_t` struct {address, count}.
- One sub-module is natural: `register_burst_address_generator`. It contains the pointer and remaining counter, the wrap logic, and the range check. The top level keeps the FSM and the output register.

## Test plan
- N=8, preload regs 0..7 = 0x10..0x17, request (2,3) with `out_ready`=1 -> beats 0x12, 0x13, 0x14 on consecutive cycles, `out_last` on 0x14, `done` one cycle later.
- Same request with `out_ready` toggling 1,0,0,1… -> identical data order, `out_data` stable while stalled, no beats lost or duplicated.
- Request (6,4): without the macro -> `error` pulse and zero beats; with the macro -> 0x16, 0x17, 0x10, 0x11.
- N=6 (non-power-of-two) with the macro, request (4,4) -> addresses 4, 5, 0, 1; request (6,1) -> `error`.
- Request (0,0) -> `done` pulse, no `out_valid`. Assert `reset_n` low mid-burst -> `out_valid`, `register_enable` and `done` drop to 0 at once, and `start_ready` is 1 once reset is released.
- The writer changes reg 3 from 0x13 to 0xAA on the same edge that captures address 3 -> 0x13 is streamed; a re-read burst of (3,1) -> 0xAA.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared types for the register file and its burst read client.
package register_file_pkg;

  localparam int unsigned REGISTER_DATA_WIDTH = 8;
  localparam int unsigned REQUEST_FIELD_WIDTH = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } burst_state_t;

  // Request fields are wide enough for any supported depth; users zero-extend.
  typedef struct packed {
    logic [REQUEST_FIELD_WIDTH-1:0] address;
    logic [REQUEST_FIELD_WIDTH-1:0] count;
  } burst_request_t;

endpackage

// File: rtl/register_burst_reader_if.sv
// Request, register-port and output-stream signals of register_burst_reader.
// master: the burst reader; slave: requester, register file and consumer.
interface register_burst_reader_if #(
  parameter int unsigned ADDRESS_WIDTH = 3,
  parameter int unsigned COUNT_WIDTH   = 4
);
  import register_file_pkg::*;

  logic                           start_valid;
  logic                           start_ready;
  logic [ADDRESS_WIDTH-1:0]       start_address;
  logic [COUNT_WIDTH-1:0]         start_count;
  logic                           register_enable;
  logic [ADDRESS_WIDTH-1:0]       register_address;
  logic [REGISTER_DATA_WIDTH-1:0] register_read_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [REGISTER_DATA_WIDTH-1:0] out_data;
  logic                           out_last;
  logic                           done;
  logic                           error;

  modport master (
    input  start_valid, start_address, start_count, register_read_data, out_ready,
    output start_ready, register_enable, register_address,
           out_valid, out_data, out_last, done, error
  );

  modport slave (
    output start_valid, start_address, start_count, register_read_data, out_ready,
    input  start_ready, register_enable, register_address,
           out_valid, out_data, out_last, done, error
  );

endinterface

// File: rtl/register_burst_address_generator.sv
// Burst pointer and remaining-beat counter with wrap and request range check.
// REGISTER_BURST_READER_WRAP_EN: bursts wrap; only the start address is checked.
module register_burst_address_generator
  import register_file_pkg::*;
#(
  parameter int unsigned NUMBER_OF_REGISTERS = 8,
  parameter int unsigned ADDRESS_WIDTH       = $clog2(NUMBER_OF_REGISTERS),
  parameter int unsigned COUNT_WIDTH         = $clog2(NUMBER_OF_REGISTERS) + 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic                     advance,
  input  burst_request_t           request,
  output logic                     request_ok_c,
  output logic [ADDRESS_WIDTH-1:0] pointer,
  output logic [COUNT_WIDTH-1:0]   remaining
);

  localparam int unsigned SPAN_WIDTH = REQUEST_FIELD_WIDTH + 1;
  localparam logic [SPAN_WIDTH-1:0]    DEPTH        = SPAN_WIDTH'(NUMBER_OF_REGISTERS);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(NUMBER_OF_REGISTERS - 1);

  logic address_in_range_c;
  assign address_in_range_c = SPAN_WIDTH'(request.address) < DEPTH;

`ifdef REGISTER_BURST_READER_WRAP_EN
  // Any count is legal, but it must fit the remaining counter.
  logic count_fits_c;
  assign count_fits_c = (request.count >> COUNT_WIDTH) == '0;
  assign request_ok_c = address_in_range_c && count_fits_c;
`else
  logic [SPAN_WIDTH-1:0] span_end_c;
  assign span_end_c   = SPAN_WIDTH'(request.address) + SPAN_WIDTH'(request.count);
  assign request_ok_c = address_in_range_c && (span_end_c <= DEPTH);
`endif

  // Explicit compare keeps non-power-of-two depths wrapping correctly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pointer   <= '0;
      remaining <= '0;
    end else if (load) begin
      pointer   <= ADDRESS_WIDTH'(request.address);
      remaining <= COUNT_WIDTH'(request.count);
    end else if (advance) begin
      pointer   <= (pointer == LAST_ADDRESS) ? '0 : pointer + ADDRESS_WIDTH'(1);
      remaining <= remaining - COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/register_burst_reader.sv
// Streams a burst of register file contents onto a valid/ready output with a last marker.
// REGISTER_BURST_READER_WRAP_EN: bursts wrap modulo the register file depth.
module register_burst_reader
  import register_file_pkg::*;
#(
  parameter int unsigned NUMBER_OF_REGISTERS = 8,
  parameter int unsigned ADDRESS_WIDTH       = $clog2(NUMBER_OF_REGISTERS),
  parameter int unsigned COUNT_WIDTH         = $clog2(NUMBER_OF_REGISTERS) + 1
) (
  input logic                    clock,
  input logic                    reset_n,
  register_burst_reader_if.master bus
);

  burst_state_t                   state;
  burst_state_t                   next_state;
  burst_request_t                 request;
  logic                           request_ok_c;
  logic                           accept;
  logic                           advance;
  logic [ADDRESS_WIDTH-1:0]       pointer;
  logic [COUNT_WIDTH-1:0]         remaining;
  logic                           out_valid_next;
  logic                           out_last_next;
  logic [REGISTER_DATA_WIDTH-1:0] out_data_next;
  logic                           done_next;
  logic                           error_next;

  assign request.address = REQUEST_FIELD_WIDTH'(bus.start_address);
  assign request.count   = REQUEST_FIELD_WIDTH'(bus.start_count);

  register_burst_address_generator #(
    .NUMBER_OF_REGISTERS (NUMBER_OF_REGISTERS),
    .ADDRESS_WIDTH       (ADDRESS_WIDTH),
    .COUNT_WIDTH         (COUNT_WIDTH)
  ) u_address_generator (
    .clock        (clock),
    .reset_n      (reset_n),
    .load         (accept),
    .advance      (advance),
    .request      (request),
    .request_ok_c (request_ok_c),
    .pointer      (pointer),
    .remaining    (remaining)
  );

  assign bus.register_address = pointer;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next state plus the next value of every registered output.
  always_comb begin
    next_state     = state;
    accept         = 1'b0;
    advance        = 1'b0;
    out_valid_next = bus.out_valid;
    out_last_next  = bus.out_last;
    out_data_next  = bus.out_data;
    done_next      = 1'b0;
    error_next     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_valid && bus.start_ready) begin
          if (!request_ok_c) begin
            error_next = 1'b1;
          end else begin
            accept = 1'b1;
            if (bus.start_count == '0) done_next  = 1'b1;
            else                       next_state = STREAM;
          end
        end
      end
      STREAM: begin
        if (bus.out_valid && bus.out_ready) begin
          out_valid_next = 1'b0;
          if (bus.out_last) begin
            next_state = IDLE;
            done_next  = 1'b1;
          end
        end
        // Register file read is combinational, so the capture sees pre-write data.
        if ((remaining != '0) && (!bus.out_valid || bus.out_ready)) begin
          advance        = 1'b1;
          out_valid_next = 1'b1;
          out_data_next  = bus.register_read_data;
          out_last_next  = (remaining == COUNT_WIDTH'(1));
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.start_ready     <= 1'b1;
      bus.register_enable <= 1'b0;
      bus.out_valid       <= 1'b0;
      bus.out_data        <= '0;
      bus.out_last        <= 1'b0;
      bus.done            <= 1'b0;
      bus.error           <= 1'b0;
    end else begin
      bus.start_ready     <= (next_state == IDLE);
      bus.register_enable <= (next_state == STREAM);
      bus.out_valid       <= out_valid_next;
      bus.out_data        <= out_data_next;
      bus.out_last        <= out_last_next;
      bus.done            <= done_next;
      bus.error           <= error_next;
    end
  end

endmodule

// File: tb/tb_register_burst_reader.sv
// Scoreboard bench for register_burst_reader: an 8-deep and a 6-deep instance,
// each with a behavioural register file, checked against a burst-level model.
module tb_register_burst_reader;
  import register_file_pkg::*;

  localparam int unsigned N_A = 8;
  localparam int unsigned N_B = 6;
  localparam int unsigned AW  = 3;
  localparam int unsigned CW  = 4;

  typedef enum int {K_BEAT = 0, K_DONE = 1, K_ERROR = 2} kind_t;
  typedef struct {
    int    id;
    kind_t kind;
    int    data;
    int    last;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_failed   = 0;
  int   ready_mode = 1;  // 0 stall, 1 always ready, 2 pattern 1,0,0, 3 random

  logic       clock;
  logic       reset_n;
  logic [7:0] regs_a [N_A];
  logic [7:0] regs_b [N_B];

  register_burst_reader_if #(.ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) bus_a ();
  register_burst_reader_if #(.ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) bus_b ();

  register_burst_reader #(.NUMBER_OF_REGISTERS(N_A), .ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW))
    dut_a (.clock(clock), .reset_n(reset_n), .bus(bus_a));
  register_burst_reader #(.NUMBER_OF_REGISTERS(N_B), .ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW))
    dut_b (.clock(clock), .reset_n(reset_n), .bus(bus_b));

  assign bus_a.register_read_data = regs_a[bus_a.register_address];
  assign bus_b.register_read_data = (bus_b.register_address < AW'(N_B)) ?
                                    regs_b[bus_b.register_address] : 8'hEE;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic void check(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endfunction

  // Reference: what a burst request must produce, from the addressing rules alone.
  function automatic void push_expect(input int id, input int addr, input int cnt);
    int   n;
    bit   bad;
    exp_t e;
    n   = (id == 0) ? N_A : N_B;
    bad = (addr >= n);
`ifndef REGISTER_BURST_READER_WRAP_EN
    bad = bad || (addr + cnt > n);
`endif
    e.id = id;
    if (bad) begin
      e.kind = K_ERROR; e.data = 0; e.last = 0;
      exp_q.push_back(e);
    end else begin
      for (int i = 0; i < cnt; i++) begin
        int a;
        a      = (addr + i) % n;
        e.kind = K_BEAT;
        e.data = (id == 0) ? int'(regs_a[a]) : int'(regs_b[a]);
        e.last = (i == cnt - 1) ? 1 : 0;
        exp_q.push_back(e);
      end
      e.kind = K_DONE; e.data = 0; e.last = 0;
      exp_q.push_back(e);
    end
  endfunction

  task automatic pop_expect(input int id, input kind_t kind, input int data, input int last);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_compared++;
      n_failed++;
      $display("FAIL unexpected_event: dut %0d kind %0d data 0x%0h, required nothing", id, kind, data);
    end else begin
      e = exp_q.pop_front();
      check("event_dut", id, e.id);
      check("event_kind", int'(kind), int'(e.kind));
      if (kind == K_BEAT && e.kind == K_BEAT) begin
        check("beat_data", data, e.data);
        check("beat_last", last, e.last);
      end
    end
  endtask

  logic       held_v [2];
  logic [7:0] held_d [2];
  logic       held_l [2];

  task automatic observe(input int id, input logic v, input logic r, input logic [7:0] d,
                         input logic l, input logic dn, input logic er);
    if (held_v[id]) begin
      check("stall_valid", int'(v), 1);
      check("stall_data", int'(d), int'(held_d[id]));
      check("stall_last", int'(l), int'(held_l[id]));
    end
    held_v[id] = v && !r;
    held_d[id] = d;
    held_l[id] = l;
    if (er)     pop_expect(id, K_ERROR, 0, 0);
    if (dn)     pop_expect(id, K_DONE, 0, 0);
    if (v && r) pop_expect(id, K_BEAT, int'(d), int'(l));
  endtask

  // Monitor: samples on the falling edge, independent of the stimulus.
  always @(negedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) held_v[k] = 1'b0;
    end else begin
      observe(0, bus_a.out_valid, bus_a.out_ready, bus_a.out_data, bus_a.out_last,
              bus_a.done, bus_a.error);
      observe(1, bus_b.out_valid, bus_b.out_ready, bus_b.out_data, bus_b.out_last,
              bus_b.done, bus_b.error);
    end
  end

  initial begin
    int pat;
    logic r;
    pat = 0;
    bus_a.out_ready = 1'b0;
    bus_b.out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       r = 1'b0;
        1:       r = 1'b1;
        2:       r = (pat % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      pat++;
      bus_a.out_ready = r;
      bus_b.out_ready = r;
    end
  end

  task automatic issue(input int id, input int addr, input int cnt);
    @(negedge clock);
    if (id == 0) begin
      bus_a.start_valid   = 1'b1;
      bus_a.start_address = AW'(addr);
      bus_a.start_count   = CW'(cnt);
    end else begin
      bus_b.start_valid   = 1'b1;
      bus_b.start_address = AW'(addr);
      bus_b.start_count   = CW'(cnt);
    end
    push_expect(id, addr, cnt);
    @(posedge clock);
    #1;
    bus_a.start_valid = 1'b0;
    bus_b.start_valid = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      #1;
      if (exp_q.size() == 0 && ((id == 0) ? bus_a.start_ready : bus_b.start_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    check("burst_completes_in_budget", int'(ok), 1);
  endtask

  initial begin
    reset_n             = 1'b0;
    bus_a.start_valid   = 1'b0;
    bus_a.start_address = '0;
    bus_a.start_count   = '0;
    bus_b.start_valid   = 1'b0;
    bus_b.start_address = '0;
    bus_b.start_count   = '0;
    for (int i = 0; i < N_A; i++) regs_a[i] = 8'(8'h10 + i);
    for (int i = 0; i < N_B; i++) regs_b[i] = 8'(8'h20 + i);

    repeat (2) @(negedge clock);
    check("reset_out_valid", int'(bus_a.out_valid), 0);
    check("reset_out_data", int'(bus_a.out_data), 0);
    check("reset_out_last", int'(bus_a.out_last), 0);
    check("reset_done", int'(bus_a.done), 0);
    check("reset_error", int'(bus_a.error), 0);
    check("reset_register_enable", int'(bus_a.register_enable), 0);
    check("reset_register_address", int'(bus_a.register_address), 0);
    check("reset_start_ready", int'(bus_a.start_ready), 1);
    check("reset_b_out_valid", int'(bus_b.out_valid), 0);
    #2 reset_n = 1'b1;

    // (2,3) fully ready: latency and done timing
    ready_mode = 1;
    issue(0, 2, 3);
    @(negedge clock);
    check("e0_out_valid", int'(bus_a.out_valid), 0);
    check("e0_register_enable", int'(bus_a.register_enable), 1);
    check("e0_register_address", int'(bus_a.register_address), 2);
    check("e0_start_ready", int'(bus_a.start_ready), 0);
    @(negedge clock);
    check("e1_out_valid", int'(bus_a.out_valid), 1);
    check("e1_out_data", int'(bus_a.out_data), 'h12);
    @(negedge clock);
    @(negedge clock);
    check("e3_out_data", int'(bus_a.out_data), 'h14);
    check("e3_out_last", int'(bus_a.out_last), 1);
    @(negedge clock);
    check("e4_done", int'(bus_a.done), 1);
    check("e4_start_ready", int'(bus_a.start_ready), 1);
    check("e4_out_valid", int'(bus_a.out_valid), 0);
    check("e4_register_enable", int'(bus_a.register_enable), 0);
    wait_idle(0);

    // Same request with a stalling consumer
    ready_mode = 2;
    issue(0, 2, 3);
    wait_idle(0);

    // Burst past the last register
    ready_mode = 1;
    issue(0, 6, 4);
    @(negedge clock);
`ifdef REGISTER_BURST_READER_WRAP_EN
    check("wrap_accept_enable", int'(bus_a.register_enable), 1);
`else
    check("overrun_error", int'(bus_a.error), 1);
    check("overrun_start_ready", int'(bus_a.start_ready), 1);
`endif
    wait_idle(0);

    // Non-power-of-two depth
    issue(1, 4, 4);
    wait_idle(1);
    issue(1, 6, 1);
    @(negedge clock);
    check("b_address_error", int'(bus_b.error), 1);
    wait_idle(1);

    // Zero-length burst
    issue(0, 0, 0);
    @(negedge clock);
    check("zero_done", int'(bus_a.done), 1);
    check("zero_out_valid", int'(bus_a.out_valid), 0);
    wait_idle(0);

    // Writer hits reg 3 on the edge that captures it
    issue(0, 2, 3);
    @(posedge clock);
    @(posedge clock);
    regs_a[3] <= 8'hAA;
    wait_idle(0);
    issue(0, 3, 1);
    wait_idle(0);

    // Randomized bursts
    for (int t = 0; t < 60; t++) begin
      int id;
      int n;
      int addr;
      int cnt;
      id   = $urandom_range(0, 1);
      n    = (id == 0) ? N_A : N_B;
      addr = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0 || addr >= n) cnt = $urandom_range(0, 15);
      else                                        cnt = $urandom_range(0, n - addr);
      ready_mode = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) regs_a[$urandom_range(0, N_A - 1)] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) regs_b[$urandom_range(0, N_B - 1)] = 8'($urandom);
      issue(id, addr, cnt);
      wait_idle(id);
    end

    // Reset in the middle of a stalled burst
    ready_mode = 0;
    issue(0, 0, 5);
    @(negedge clock);
    @(negedge clock);
    check("pre_reset_out_valid", int'(bus_a.out_valid), 1);
    #1 reset_n = 1'b0;
    #1;
    check("midreset_out_valid", int'(bus_a.out_valid), 0);
    check("midreset_register_enable", int'(bus_a.register_enable), 0);
    check("midreset_done", int'(bus_a.done), 0);
    exp_q.delete();
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    check("post_reset_start_ready", int'(bus_a.start_ready), 1);
    check("post_reset_out_valid", int'(bus_a.out_valid), 0);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
